hex_display_scanner: RTL

// Parametrised multi-digit hexadecimal 7-segment display driver. It time-multiplexes
// NUM_DIGITS common-anode/cathode digits from a registered shadow value. Per-digit

---
 rtl/hex_display_scanner.sv | 109 ++++++++++
 1 files changed

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex 7-segment driver: one digit per REFRESH_DIV-cycle slot,
// with a shadow value that is applied only at frame wrap so no frame is torn.
module hex_display_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_AN  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    pending
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [6:0] hexenc(input logic [3:0] n);
        case (n)
            4'h0: hexenc = 7'h3F;  4'h1: hexenc = 7'h06;
            4'h2: hexenc = 7'h5B;  4'h3: hexenc = 7'h4F;
            4'h4: hexenc = 7'h66;  4'h5: hexenc = 7'h6D;
            4'h6: hexenc = 7'h7D;  4'h7: hexenc = 7'h07;
            4'h8: hexenc = 7'h7F;  4'h9: hexenc = 7'h6F;
            4'hA: hexenc = 7'h77;  4'hB: hexenc = 7'h7C;
            4'hC: hexenc = 7'h39;  4'hD: hexenc = 7'h5E;
            4'hE: hexenc = 7'h79;  default: hexenc = 7'h71;
        endcase
    endfunction

    logic [PW-1:0]                prescaler;
    logic [DW-1:0]                digit_idx;
    logic [NUM_DIGITS-1:0][3:0]   disp_val, shadow_val;
    logic [NUM_DIGITS-1:0]        disp_dp, shadow_dp;
    logic [NUM_DIGITS-1:0]        zero_from, an_hot;
    logic                         slot_end, frame_end, blank;
    logic [6:0]                   seg_lit;

    assign slot_end  = (prescaler == PW'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (digit_idx == DW'(NUM_DIGITS - 1));

    // zero_from[k]: every nibble from k up to the most significant is zero
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_zero
        assign zero_from[k] = (disp_val[NUM_DIGITS-1:k] == '0);
    end

    always_comb begin
        an_hot = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            an_hot[i] = (digit_idx == DW'(i));
    end

    assign blank   = blank_lz && (digit_idx != '0) && zero_from[digit_idx];
    assign seg_lit = blank ? 7'h00 : hexenc(disp_val[digit_idx]);

    // Scan timing and the shadow/display value handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            prescaler <= slot_end ? '0 : prescaler + 1'b1;
            if (slot_end)
                digit_idx <= frame_end ? '0 : digit_idx + 1'b1;
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end
            if (frame_end) begin
                // A load landing on the wrap goes straight to the display
                if (load) begin
                    disp_val <= value;
                    disp_dp  <= dp_in;
                end else if (pending) begin
                    disp_val <= shadow_val;
                    disp_dp  <= shadow_dp;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= {7{ACTIVE_LOW_SEG}};
            dp         <= ACTIVE_LOW_SEG;
            an         <= {NUM_DIGITS{ACTIVE_LOW_AN}};
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_lit ^ {7{ACTIVE_LOW_SEG}};
            dp         <= disp_dp[digit_idx] ^ ACTIVE_LOW_SEG;
            an         <= an_hot ^ {NUM_DIGITS{ACTIVE_LOW_AN}};
            frame_tick <= frame_end;
        end
    end
endmodule
